alu_ctrl_mdu: RTL

Parametrised successor to the single-cycle ALU decoder. Combinationally decodes aluop/funct3/funct7 into a 4-bit ALU control code with the full RV32I operation set. Adds an iterative multiply/divide sequencer for the M-extension (funct7=0000001). The sequencer stalls the single-cycle datapath while it runs and returns the result through a one-cycle done pulse.

---
 rtl/alu_ctrl_mdu.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - RV32I ALU control decoder with iterative M-extension mul/div sequencer
module alu_ctrl_mdu #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_ctrl,
    output logic            is_muldiv,
    output logic            stall,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SRA  = 4'b1000;
    localparam logic [3:0] C_SLTU = 4'b1001;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } md_state_t;

    md_state_t state, state_nxt;

    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [2:0]        f3_q;
    logic              neg_a_q;
    logic              neg_b_q;

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = C_ADD;
            3'b001:  base_op = C_SLL;
            3'b010:  base_op = C_SLT;
            3'b011:  base_op = C_SLTU;
            3'b100:  base_op = C_XOR;
            3'b101:  base_op = C_SRL;
            3'b110:  base_op = C_OR;
            default: base_op = C_AND;
        endcase
    endfunction

    always_comb begin
        alu_ctrl = C_AND;
        case (aluop)
            2'b00: alu_ctrl = C_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: alu_ctrl = C_SUB;
                    3'b100, 3'b101: alu_ctrl = C_SLT;
                    3'b110, 3'b111: alu_ctrl = C_SLTU;
                    default:        alu_ctrl = C_AND;
                endcase
            end
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    alu_ctrl = base_op(funct3);
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        alu_ctrl = C_SUB;
                    end else if (funct3 == 3'b101) begin
                        alu_ctrl = C_SRA;
                    end
                end
            end
            default: begin
                // I-type shifts carry the SRA selector in imm[10], i.e. funct7[5]
                if (funct3 == 3'b101 && funct7[5]) begin
                    alu_ctrl = C_SRA;
                end else begin
                    alu_ctrl = base_op(funct3);
                end
            end
        endcase
    end

    assign is_muldiv = ENABLE_M && (aluop == 2'b10) && (funct7 == 7'b0000001);

    logic accept;
    assign accept = start && is_muldiv && (state == S_IDLE);

    logic            is_div_in;
    logic            sgn_a, sgn_b;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div_in   = funct3[2];
        sgn_a       = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
        sgn_b       = is_div_in ? ~funct3[0] : ~funct3[1];
        neg_a       = sgn_a && op_a[XLEN-1];
        neg_b       = sgn_b && op_b[XLEN-1];
        abs_a       = neg_a ? (~op_a + 1'b1) : op_a;
        abs_b       = neg_b ? (~op_b + 1'b1) : op_b;
        div_zero    = is_div_in && (op_b == '0);
        div_ovf     = is_div_in && ~funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   final_res;

    // Multiply keeps the multiplier in acc's low half and the partial product above it;
    // divide keeps the remainder above and the dividend/quotient below.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
        shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = shifted - {1'b0, mcand};
        acc_step = acc;
        if (!f3_q[2]) begin
            acc_step = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end

        prod_s = (neg_a_q ^ neg_b_q) ? (~acc_step + 1'b1) : acc_step;
        quo    = (neg_a_q ^ neg_b_q) ? (~acc_step[XLEN-1:0] + 1'b1) : acc_step[XLEN-1:0];
        rem    = neg_a_q ? (~acc_step[2*XLEN-1:XLEN] + 1'b1) : acc_step[2*XLEN-1:XLEN];

        if (!f3_q[2]) begin
            final_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else begin
            final_res = f3_q[1] ? rem : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        md_busy   = 1'b0;
        md_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = special ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (count == CW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Released in DONE so the retiring instruction can write back md_result
        stall   = (start && is_muldiv && (state != S_DONE)) || (state == S_RUN);
        md_busy = (state != S_IDLE);
        md_done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            f3_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            md_result <= '0;
        end else if (accept) begin
            count   <= CW'(XLEN);
            f3_q    <= funct3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            if (is_div_in) begin
                acc   <= {{XLEN{1'b0}}, abs_a};
                mcand <= abs_b;
            end else begin
                acc   <= {{XLEN{1'b0}}, abs_b};
                mcand <= abs_a;
            end
            if (special) begin
                md_result <= special_res;
            end
        end else if (state == S_RUN) begin
            acc   <= acc_step;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                md_result <= final_res;
            end
        end
    end

endmodule
